// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sample-history blocks: default sizes,
// a constant clog2 helper and lane-slicing macros for packed tap buses.
`ifndef DDS_PKG_SV
`define DDS_PKG_SV

// Lane idx of width w inside a packed multi-lane bus.
`define TDL_LANE(idx, w) ((idx) * (w)) +: (w)

package dds_pkg;

   localparam int DEFAULT_SIG_WIDTH = 16;
   localparam int DEFAULT_DEPTH     = 512;
   localparam int DEFAULT_NUM_TAPS  = 4;

   // Ceiling log2, usable in constant expressions; clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

`endif

// File: rtl/tdl_ram.sv
// Sample store for tapped_delay_line: DEPTH x SIG_WIDTH array with one
// synchronous write port and NUM_PORTS asynchronous read ports, so every
// tap sees the pre-write contents on the edge that writes a new sample.
module tdl_ram import dds_pkg::*; #(
   parameter int SIG_WIDTH = DEFAULT_SIG_WIDTH,
   parameter int DEPTH     = DEFAULT_DEPTH,
   parameter int NUM_PORTS = DEFAULT_NUM_TAPS,
   parameter int ADDR_W    = clog2(DEPTH)
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [ADDR_W-1:0]              waddr,
   input  logic [SIG_WIDTH-1:0]           wdata,
   input  logic [NUM_PORTS*ADDR_W-1:0]    rd_addr,
   output logic [NUM_PORTS*SIG_WIDTH-1:0] rd_data
);

   logic [SIG_WIDTH-1:0] mem_q [DEPTH];

   // Write port: contents are deliberately left unreset; the primed logic hides stale data.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Asynchronous read ports, one per tap.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         rd_data[`TDL_LANE(i, SIG_WIDTH)] = mem_q[rd_addr[`TDL_LANE(i, ADDR_W)]];
      end
   end

endmodule

// File: rtl/tapped_delay_line.sv
// Circular-buffer delay line with NUM_TAPS run-time programmable read taps.
// Each tap reports a primed flag; unprimed taps output zero so unfilled
// history never appears as data. clr restarts history without touching RAM.
// Optional feature macro TDL_TAP_SUM_EN adds a registered signed sum of all
// tap lanes (tap_sum / sum_valid), one cycle behind out_valid.
module tapped_delay_line import dds_pkg::*; #(
   parameter int SIG_WIDTH = DEFAULT_SIG_WIDTH,
   parameter int DEPTH     = DEFAULT_DEPTH,
   parameter int NUM_TAPS  = DEFAULT_NUM_TAPS
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  clr,
   input  logic                                  en,
   input  logic [SIG_WIDTH-1:0]                  sr_in,
   input  logic [NUM_TAPS*clog2(DEPTH)-1:0]      tap_delay,
   output logic [NUM_TAPS*SIG_WIDTH-1:0]         tap_out,
   output logic [NUM_TAPS-1:0]                   tap_primed,
`ifdef TDL_TAP_SUM_EN
   output logic signed [SIG_WIDTH+clog2(NUM_TAPS)-1:0] tap_sum,
   output logic                                  sum_valid,
`endif
   output logic                                  out_valid
);

   localparam int ADDR_W = clog2(DEPTH);

   logic [ADDR_W-1:0]             wptr_q, wptr_d;
   logic [ADDR_W-1:0]             fill_cnt_q, fill_cnt_d;
   logic [NUM_TAPS*SIG_WIDTH-1:0] tap_out_q, tap_out_d;
   logic [NUM_TAPS-1:0]           tap_primed_q, tap_primed_d;
   logic                          out_valid_q, out_valid_d;

   logic                          we_s;
   logic [ADDR_W-1:0]             delay_eff_s [NUM_TAPS];
   logic [NUM_TAPS*ADDR_W-1:0]    rd_addr_s;
   logic [NUM_TAPS*SIG_WIDTH-1:0] rd_data_s;
   logic [NUM_TAPS*SIG_WIDTH-1:0] tap_data_s;
   logic [NUM_TAPS-1:0]           primed_s;

   // A sample is stored only when it is accepted (clr and rst discard it).
   assign we_s = en & ~clr & ~rst;

   tdl_ram #(
      .SIG_WIDTH (SIG_WIDTH),
      .DEPTH     (DEPTH),
      .NUM_PORTS (NUM_TAPS),
      .ADDR_W    (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .we      (we_s),
      .waddr   (wptr_q),
      .wdata   (sr_in),
      .rd_addr (rd_addr_s),
      .rd_data (rd_data_s)
   );

   // Per-tap effective delay (0 behaves as 1), read address, primed flag and gated data.
   always_comb begin
      rd_addr_s  = '0;
      tap_data_s = '0;
      primed_s   = '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
         if (tap_delay[`TDL_LANE(i, ADDR_W)] == {ADDR_W{1'b0}}) begin
            delay_eff_s[i] = ADDR_W'(1);
         end else begin
            delay_eff_s[i] = tap_delay[`TDL_LANE(i, ADDR_W)];
         end
         rd_addr_s[`TDL_LANE(i, ADDR_W)] = wptr_q - delay_eff_s[i];
         primed_s[i] = (fill_cnt_q >= delay_eff_s[i]);
         if (primed_s[i]) begin
            tap_data_s[`TDL_LANE(i, SIG_WIDTH)] = rd_data_s[`TDL_LANE(i, SIG_WIDTH)];
         end else begin
            tap_data_s[`TDL_LANE(i, SIG_WIDTH)] = {SIG_WIDTH{1'b0}};
         end
      end
   end

   // Next-state: clr restarts history, an accepted sample advances it, otherwise outputs hold.
   always_comb begin
      wptr_d       = wptr_q;
      fill_cnt_d   = fill_cnt_q;
      tap_out_d    = tap_out_q;
      tap_primed_d = tap_primed_q;
      out_valid_d  = 1'b0;
      if (clr) begin
         wptr_d       = {ADDR_W{1'b0}};
         fill_cnt_d   = {ADDR_W{1'b0}};
         tap_out_d    = '0;
         tap_primed_d = '0;
      end else if (en) begin
         wptr_d       = wptr_q + ADDR_W'(1);
         if (fill_cnt_q == ADDR_W'(DEPTH - 1)) begin
            fill_cnt_d = fill_cnt_q;
         end else begin
            fill_cnt_d = fill_cnt_q + ADDR_W'(1);
         end
         tap_out_d    = tap_data_s;
         tap_primed_d = primed_s;
         out_valid_d  = 1'b1;
      end else begin
         out_valid_d  = 1'b0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q       <= {ADDR_W{1'b0}};
         fill_cnt_q   <= {ADDR_W{1'b0}};
         tap_out_q    <= '0;
         tap_primed_q <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         wptr_q       <= wptr_d;
         fill_cnt_q   <= fill_cnt_d;
         tap_out_q    <= tap_out_d;
         tap_primed_q <= tap_primed_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign tap_out    = tap_out_q;
   assign tap_primed = tap_primed_q;
   assign out_valid  = out_valid_q;

`ifdef TDL_TAP_SUM_EN
   localparam int SUM_W = SIG_WIDTH + clog2(NUM_TAPS);

   logic signed [SUM_W-1:0]     tap_sum_q, tap_sum_d;
   logic                        sum_valid_q, sum_valid_d;
   logic signed [SIG_WIDTH-1:0] lane_s [NUM_TAPS];

   // Sum registered tap lanes (unprimed lanes are already zero) one cycle after out_valid.
   always_comb begin
      tap_sum_d   = tap_sum_q;
      sum_valid_d = 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
         lane_s[i] = tap_out_q[`TDL_LANE(i, SIG_WIDTH)];
      end
      if (clr) begin
         tap_sum_d   = '0;
         sum_valid_d = 1'b0;
      end else if (out_valid_q) begin
         tap_sum_d = '0;
         for (int i = 0; i < NUM_TAPS; i++) begin
            tap_sum_d = tap_sum_d + SUM_W'(lane_s[i]);
         end
         sum_valid_d = 1'b1;
      end else begin
         sum_valid_d = 1'b0;
      end
   end

   // Summer output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         tap_sum_q   <= '0;
         sum_valid_q <= 1'b0;
      end else begin
         tap_sum_q   <= tap_sum_d;
         sum_valid_q <= sum_valid_d;
      end
   end

   assign tap_sum   = tap_sum_q;
   assign sum_valid = sum_valid_q;
`endif

endmodule

// File: tb/tb_tapped_delay_line.sv
// Directed bench for tapped_delay_line at DEPTH=16, NUM_TAPS=2, SIG_WIDTH=16.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_tapped_delay_line;

   localparam int SW = 16;
   localparam int DP = 16;
   localparam int NT = 2;
   localparam int AW = 4;

   logic           clk;
   logic           rst;
   logic           clr;
   logic           en;
   logic [SW-1:0]  sr_in;
   logic [NT*AW-1:0] tap_delay;
   logic [NT*SW-1:0] tap_out;
   logic [NT-1:0]  tap_primed;
   logic           out_valid;
`ifdef TDL_TAP_SUM_EN
   logic signed [SW:0] tap_sum;
   logic           sum_valid;
`endif

   int n_checks;
   int n_errors;

   tapped_delay_line #(
      .SIG_WIDTH (SW),
      .DEPTH     (DP),
      .NUM_TAPS  (NT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .en         (en),
      .sr_in      (sr_in),
      .tap_delay  (tap_delay),
      .tap_out    (tap_out),
      .tap_primed (tap_primed),
`ifdef TDL_TAP_SUM_EN
      .tap_sum    (tap_sum),
      .sum_valid  (sum_valid),
`endif
      .out_valid  (out_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic e, input logic c, input logic [SW-1:0] x);
      en    = e;
      clr   = c;
      sr_in = x;
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic v, input logic [1:0] p,
                            input logic [15:0] t0, input logic [15:0] t1);
      check_eq({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
      check_eq({tag, "_primed"}, {30'd0, tap_primed}, {30'd0, p});
      check_eq({tag, "_tap0"}, {16'd0, tap_out[15:0]}, {16'd0, t0});
      check_eq({tag, "_tap1"}, {16'd0, tap_out[31:16]}, {16'd0, t1});
   endtask

   initial begin
      logic [15:0] e0;
      logic [15:0] e1;
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b1;
      clr       = 1'b0;
      en        = 1'b0;
      sr_in     = 16'h0000;
      tap_delay = {4'd5, 4'd1};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_out("reset", 1'b0, 2'b00, 16'h0000, 16'h0000);
      rst = 1'b0;

      // Priming: delays {1,5}, inputs 1..10
      for (int k = 1; k <= 10; k++) begin
         step(1'b1, 1'b0, 16'(k));
         e0 = (k >= 2) ? 16'(k - 1) : 16'h0000;
         e1 = (k >= 6) ? 16'(k - 5) : 16'h0000;
         check_out($sformatf("prime%0d", k), 1'b1, {k >= 6, k >= 2}, e0, e1);
      end

      // Clear with no sample
      step(1'b0, 1'b1, 16'h1234);
      check_out("clr0", 1'b0, 2'b00, 16'h0000, 16'h0000);

      // Wrap: delays {15,0}, 40 samples 100+k
      tap_delay = {4'd0, 4'd15};
      for (int k = 0; k < 40; k++) begin
         step(1'b1, 1'b0, 16'(100 + k));
         e0 = (k >= 15) ? 16'(100 + k - 15) : 16'h0000;
         e1 = (k >= 1) ? 16'(100 + k - 1) : 16'h0000;
         check_out($sformatf("wrap%0d", k), 1'b1, {k >= 1, k >= 15}, e0, e1);
      end

      // Gapped input: tap0 d=1, tap1 d=2; en 1,0,0,1
      tap_delay = {4'd2, 4'd1};
      step(1'b1, 1'b0, 16'h0AAA);
      check_out("gap_a", 1'b1, 2'b11, 16'd139, 16'd138);
      step(1'b0, 1'b0, 16'hDEAD);
      check_out("gap_h1", 1'b0, 2'b11, 16'd139, 16'd138);
      step(1'b0, 1'b0, 16'hBEEF);
      check_out("gap_h2", 1'b0, 2'b11, 16'd139, 16'd138);
      step(1'b1, 1'b0, 16'h0BBB);
      check_out("gap_b", 1'b1, 2'b11, 16'h0AAA, 16'd139);

      // Clear collision after 20 samples
      step(1'b0, 1'b1, 16'h0000);
      tap_delay = {4'd1, 4'd1};
      for (int k = 1; k <= 20; k++) begin
         step(1'b1, 1'b0, 16'(k));
      end
      check_out("pre_clr", 1'b1, 2'b11, 16'd19, 16'd19);
      step(1'b1, 1'b1, 16'h7FFF);
      check_out("clr_hit", 1'b0, 2'b00, 16'h0000, 16'h0000);
      step(1'b1, 1'b0, 16'h0001);
      check_out("clr_s1", 1'b1, 2'b00, 16'h0000, 16'h0000);
      step(1'b1, 1'b0, 16'h0002);
      check_out("clr_s2", 1'b1, 2'b11, 16'h0001, 16'h0001);

      // Mid-stream delay change: d0 3 -> 7 at sample 30
      step(1'b0, 1'b1, 16'h0000);
      tap_delay = {4'd1, 4'd3};
      for (int k = 0; k < 36; k++) begin
         if (k == 30) begin
            tap_delay = {4'd1, 4'd7};
         end
         step(1'b1, 1'b0, 16'(16'h0200 + k));
         if (k < 3) begin
            e0 = 16'h0000;
         end else if (k < 30) begin
            e0 = 16'(16'h0200 + k - 3);
         end else begin
            e0 = 16'(16'h0200 + k - 7);
         end
         check_eq($sformatf("dchg%0d_tap0", k), {16'd0, tap_out[15:0]}, {16'd0, e0});
      end

`ifdef TDL_TAP_SUM_EN
      // Summer: 0x7FFF + 0x7FFF, then -1 + -1
      step(1'b0, 1'b1, 16'h0000);
      check_eq("sum_clr", {15'd0, sum_valid, tap_sum[15:0]}, 32'h0);
      tap_delay = {4'd2, 4'd1};
      step(1'b1, 1'b0, 16'h7FFF);
      step(1'b1, 1'b0, 16'h7FFF);
      step(1'b1, 1'b0, 16'h0000);
      check_out("sum_pos", 1'b1, 2'b11, 16'h7FFF, 16'h7FFF);
      step(1'b0, 1'b0, 16'h0000);
      check_eq("sum_pos_valid", {31'd0, sum_valid}, 32'd1);
      check_eq("sum_pos_val", {15'd0, tap_sum}, {15'd0, 17'h0FFFE});
      step(1'b0, 1'b0, 16'h0000);
      check_eq("sum_pos_drop", {31'd0, sum_valid}, 32'd0);
      step(1'b0, 1'b1, 16'h0000);
      step(1'b1, 1'b0, 16'hFFFF);
      step(1'b1, 1'b0, 16'hFFFF);
      step(1'b1, 1'b0, 16'h0000);
      step(1'b0, 1'b0, 16'h0000);
      check_eq("sum_neg_valid", {31'd0, sum_valid}, 32'd1);
      check_eq("sum_neg_val", {15'd0, tap_sum}, {15'd0, 17'h1FFFE});
`endif

      // Reset after activity
      rst = 1'b1;
      step(1'b1, 1'b0, 16'h5555);
      check_out("rst2", 1'b0, 2'b00, 16'h0000, 16'h0000);
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
